// File: rtl/dual_rail_rx_pkg.sv
// Shared types and rail-code constants for the dual-rail receiver and its helpers.
package dual_rail_rx_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } rxState_e;

   // {true rail, complement rail} pairs that carry a legal bit value
   localparam logic [1:0] CODE_ONE  = 2'b10;
   localparam logic [1:0] CODE_ZERO = 2'b01;

endpackage

// File: rtl/dual_rail_decode.sv
// Combinational dual-rail pair decoder: yields the carried bit and whether the code is legal.
module dual_rail_decode
   import dual_rail_rx_pkg::*;
(
   input  logic rail_p_i,
   input  logic rail_n_i,
   output logic bit_o,
   output logic code_ok_o
);

   logic [1:0] pair;

   always_comb begin
      pair      = {rail_p_i, rail_n_i};
      bit_o     = (pair == CODE_ONE);
      code_ok_o = (pair == CODE_ONE) || (pair == CODE_ZERO);
   end

endmodule

// File: rtl/dual_rail_rx.sv
// Dual-rail receiver: checks q/qbar pairs, deserialises LSB-first words and offers them
// on a valid/ready output register, with a saturating code-error count and sticky overrun.
module dual_rail_rx
   import dual_rail_rx_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             bit_en_i,
   input  logic             rail_p_i,
   input  logic             rail_n_i,
   input  logic             clr_err_i,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o,
   output logic             out_valid_o,
   output logic             code_err_o,
   output logic             overrun_o,
   output logic [CNT_W-1:0] err_cnt_o
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   rxState_e         state_q, state_d;
   logic [IDX_W-1:0] bitIdx_q, bitIdx_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] outData_q, outData_d;
   logic             outValid_q, outValid_d;
   logic             codeErr_q, codeErr_d;
   logic             overrun_q, overrun_d;
   logic [CNT_W-1:0] errCnt_q, errCnt_d;

   logic             rxBit;
   logic             codeOk;
   logic [IDX_W-1:0] curIdx;
   logic             wordDone;
   logic             badCode;
   logic             loadWord;
   logic             dropWord;

   dual_rail_decode uDecode (
      .rail_p_i  (rail_p_i),
      .rail_n_i  (rail_n_i),
      .bit_o     (rxBit),
      .code_ok_o (codeOk)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         bitIdx_q   <= '0;
         shift_q    <= '0;
         outData_q  <= '0;
         outValid_q <= 1'b0;
         codeErr_q  <= 1'b0;
         overrun_q  <= 1'b0;
         errCnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         bitIdx_q   <= bitIdx_d;
         shift_q    <= shift_d;
         outData_q  <= outData_d;
         outValid_q <= outValid_d;
         codeErr_q  <= codeErr_d;
         overrun_q  <= overrun_d;
         errCnt_q   <= errCnt_d;
      end
   end

   // A new word always starts at index 0; an illegal pair throws away the partial word.
   always_comb begin
      state_d  = state_q;
      bitIdx_d = bitIdx_q;
      shift_d  = shift_q;
      wordDone = 1'b0;
      badCode  = 1'b0;
      curIdx   = (state_q == IDLE) ? '0 : bitIdx_q;
      if (bit_en_i) begin
         if (!codeOk) begin
            badCode  = 1'b1;
            state_d  = IDLE;
            bitIdx_d = '0;
            shift_d  = '0;
         end else begin
            shift_d[curIdx] = rxBit;
            if (curIdx == LAST_IDX) begin
               wordDone = 1'b1;
               state_d  = IDLE;
               bitIdx_d = '0;
            end else begin
               state_d  = SHIFT;
               bitIdx_d = curIdx + 1'b1;
            end
         end
      end
   end

   // Clearing takes priority over a same-cycle error increment or overrun set.
   always_comb begin
      loadWord   = wordDone && (!outValid_q || out_ready_i);
      dropWord   = wordDone && outValid_q && !out_ready_i;
      outData_d  = loadWord ? shift_d : outData_q;
      outValid_d = outValid_q;
      if (loadWord) begin
         outValid_d = 1'b1;
      end else if (outValid_q && out_ready_i) begin
         outValid_d = 1'b0;
      end
      codeErr_d = badCode;
      overrun_d = overrun_q;
      errCnt_d  = errCnt_q;
      if (clr_err_i) begin
         overrun_d = 1'b0;
         errCnt_d  = '0;
      end else begin
         if (dropWord) begin
            overrun_d = 1'b1;
         end
         if (badCode && (errCnt_q != CNT_MAX)) begin
            errCnt_d = errCnt_q + 1'b1;
         end
      end
   end

   assign out_data_o  = outData_q;
   assign out_valid_o = outValid_q;
   assign code_err_o  = codeErr_q;
   assign overrun_o   = overrun_q;
   assign err_cnt_o   = errCnt_q;

endmodule

// File: tb/tb_dual_rail_rx.sv
// Directed self-checking bench for dual_rail_rx; a second instance with a 2-bit
// error counter shares the stimulus to exercise saturation.
module tb_dual_rail_rx;

   logic       clk;
   logic       rst_n;
   logic       bitEn;
   logic       railP;
   logic       railN;
   logic       clrErr;
   logic       outReady;

   logic [7:0] outData;
   logic       outValid;
   logic       codeErr;
   logic       overrun;
   logic [7:0] errCnt;

   logic [7:0] outDataB;
   logic       outValidB;
   logic       codeErrB;
   logic       overrunB;
   logic [1:0] errCntB;

   int checks;
   int errors;

   dual_rail_rx #(.WIDTH(8), .CNT_W(8)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .bit_en_i    (bitEn),
      .rail_p_i    (railP),
      .rail_n_i    (railN),
      .clr_err_i   (clrErr),
      .out_ready_i (outReady),
      .out_data_o  (outData),
      .out_valid_o (outValid),
      .code_err_o  (codeErr),
      .overrun_o   (overrun),
      .err_cnt_o   (errCnt)
   );

   dual_rail_rx #(.WIDTH(8), .CNT_W(2)) dutSat (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .bit_en_i    (bitEn),
      .rail_p_i    (railP),
      .rail_n_i    (railN),
      .clr_err_i   (clrErr),
      .out_ready_i (outReady),
      .out_data_o  (outDataB),
      .out_valid_o (outValidB),
      .code_err_o  (codeErrB),
      .overrun_o   (overrunB),
      .err_cnt_o   (errCntB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one strobed rail pair; returns 1ns after the sampling edge.
   task automatic applyBit(input logic p, input logic n, input logic clr);
      @(negedge clk);
      bitEn  = 1'b1;
      railP  = p;
      railN  = n;
      clrErr = clr;
      @(posedge clk);
      #1;
      bitEn  = 1'b0;
      clrErr = 1'b0;
   endtask

   task automatic applyWord(input logic [7:0] w);
      for (int i = 0; i < 8; i++) applyBit(w[i], ~w[i], 1'b0);
   endtask

   task automatic applyClear();
      @(negedge clk);
      clrErr = 1'b1;
      @(posedge clk);
      #1;
      clrErr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", outValid); end
      checks++; if (errCnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_errcnt: got %0d expected 0", errCnt); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
      checks++; if (codeErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_codeerr: got %b expected 0", codeErr); end
      checks++; if (outData !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", outData); end
   endtask

   task automatic test_good_word();
      outReady = 1'b1;
      applyWord(8'hA5);
      checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL good_valid: got %b expected 1", outValid); end
      checks++; if (outData !== 8'hA5) begin errors++; $display("[TB] FAIL good_data: got %h expected a5", outData); end
      @(posedge clk);
      #1;
      checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL good_valid_drop: got %b expected 0", outValid); end
   endtask

   task automatic test_backpressure();
      outReady = 1'b0;
      applyWord(8'h3C);
      checks++; if (outData !== 8'h3C) begin errors++; $display("[TB] FAIL bp_first_data: got %h expected 3c", outData); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_overrun: got %b expected 0", overrun); end
      applyWord(8'hFF);
      checks++; if (outData !== 8'h3C) begin errors++; $display("[TB] FAIL bp_data_held: got %h expected 3c", outData); end
      checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid_held: got %b expected 1", outValid); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL bp_overrun: got %b expected 1", overrun); end
      applyClear();
      checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL bp_overrun_clr: got %b expected 0", overrun); end
   endtask

   task automatic test_code_error();
      outReady = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL ce_drain: got %b expected 0", outValid); end
      applyBit(1'b1, 1'b0, 1'b0);
      applyBit(1'b0, 1'b1, 1'b0);
      applyBit(1'b1, 1'b0, 1'b0);
      applyBit(1'b1, 1'b1, 1'b0);
      checks++; if (codeErr !== 1'b1) begin errors++; $display("[TB] FAIL ce_pulse: got %b expected 1", codeErr); end
      checks++; if (errCnt !== 8'd1) begin errors++; $display("[TB] FAIL ce_count: got %0d expected 1", errCnt); end
      @(posedge clk);
      #1;
      checks++; if (codeErr !== 1'b0) begin errors++; $display("[TB] FAIL ce_pulse_end: got %b expected 0", codeErr); end
      checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL ce_no_word: got %b expected 0", outValid); end
      applyWord(8'h0F);
      checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL ce_next_valid: got %b expected 1", outValid); end
      checks++; if (outData !== 8'h0F) begin errors++; $display("[TB] FAIL ce_next_data: got %h expected 0f", outData); end
   endtask

   task automatic test_saturation();
      applyClear();
      checks++; if (errCntB !== 2'd0) begin errors++; $display("[TB] FAIL sat_pre_clear: got %0d expected 0", errCntB); end
      for (int i = 0; i < 5; i++) applyBit(1'b0, 1'b0, 1'b0);
      checks++; if (errCntB !== 2'd3) begin errors++; $display("[TB] FAIL sat_hold: got %0d expected 3", errCntB); end
      checks++; if (errCnt !== 8'd5) begin errors++; $display("[TB] FAIL sat_wide_count: got %0d expected 5", errCnt); end
      applyBit(1'b1, 1'b1, 1'b1);
      checks++; if (errCntB !== 2'd0) begin errors++; $display("[TB] FAIL sat_clr_wins: got %0d expected 0", errCntB); end
      checks++; if (errCnt !== 8'd0) begin errors++; $display("[TB] FAIL sat_clr_wide: got %0d expected 0", errCnt); end
      checks++; if (codeErr !== 1'b1) begin errors++; $display("[TB] FAIL sat_clr_pulse: got %b expected 1", codeErr); end
   endtask

   task automatic test_reset_mid_word();
      outReady = 1'b0;
      @(posedge clk);
      #1;
      applyBit(1'b1, 1'b1, 1'b0);
      applyWord(8'h55);
      checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL rm_pre_valid: got %b expected 1", outValid); end
      applyBit(1'b1, 1'b0, 1'b0);
      applyBit(1'b1, 1'b0, 1'b0);
      applyBit(1'b0, 1'b1, 1'b0);
      applyBit(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL rm_valid: got %b expected 0", outValid); end
      checks++; if (outData !== 8'h00) begin errors++; $display("[TB] FAIL rm_data: got %h expected 00", outData); end
      checks++; if (errCnt !== 8'd0) begin errors++; $display("[TB] FAIL rm_errcnt: got %0d expected 0", errCnt); end
      checks++; if (overrun !== 1'b0 || codeErr !== 1'b0) begin errors++; $display("[TB] FAIL rm_flags: got overrun=%b code_err=%b expected 0 0", overrun, codeErr); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n    = 1'b1;
      outReady = 1'b1;
      applyWord(8'h81);
      checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL rm_after_valid: got %b expected 1", outValid); end
      checks++; if (outData !== 8'h81) begin errors++; $display("[TB] FAIL rm_after_data: got %h expected 81", outData); end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      bitEn    = 1'b0;
      railP    = 1'b0;
      railN    = 1'b0;
      clrErr   = 1'b0;
      outReady = 1'b0;
      test_reset();
      test_good_word();
      test_backpressure();
      test_code_error();
      test_saturation();
      test_reset_mid_word();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
